// File: rtl/option_feeder.sv
// option_feeder: FIFO of line options feeding a puzzle solver.
// Loads a puzzle's options from the parser, then serves them one per
// new_line pop, accepting put_back words re-queued at the tail.
// Optional macro OPTION_FEEDER_STATS_EN adds pop/put_back counters.
module option_feeder #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic [WIDTH-1:0]           load_option,
    input  logic                       load_last,
    output logic                       load_ready,
    output logic                       started,
    input  logic                       new_line,
    output logic [WIDTH-1:0]           option,
    output logic                       option_valid,
    input  logic                       put_back,
    input  logic [WIDTH-1:0]           put_back_option,
    input  logic                       solved,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
`ifdef OPTION_FEEDER_STATS_EN
    ,
    output logic [31:0]                pop_total,
    output logic [31:0]                push_back_total
`endif
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head, tail;
    logic             load_push, pb_push, push, pop;
    logic [WIDTH-1:0] wdata;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A full FIFO still takes a put_back when the same cycle pops a word.
    assign load_push = (state_q == LOAD) && load_valid && !full;
    assign pop       = (state_q == SERVE) && new_line && !empty;
    assign pb_push   = (state_q == SERVE) && put_back && (!full || pop);
    assign push      = load_push || pb_push;
    assign wdata     = (state_q == LOAD) ? load_option : put_back_option;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and load handshake
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        case (state_q)
            IDLE:  if (load_start) state_d = LOAD;
            LOAD: begin
                load_ready = !full;
                if (load_valid && !full && load_last) state_d = SERVE;
            end
            SERVE: if (solved) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pointers and occupancy; leaving SERVE empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (state_q == SERVE && solved) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= nxt(tail);
            if (pop)  head <= nxt(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= wdata;
    end

    // Registered pop result, start pulse and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            option       <= '0;
            option_valid <= 1'b0;
            started      <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            option_valid <= pop;
            if (pop) option <= mem[head];
            started <= (state_q == LOAD) && (state_d == SERVE);
            if (state_q == SERVE && put_back && full && !pop) overflow <= 1'b1;
            if (state_q == SERVE && new_line && empty)        underflow <= 1'b1;
        end
    end

`ifdef OPTION_FEEDER_STATS_EN
    // Saturating activity counters, cleared when a new puzzle starts loading
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_total       <= '0;
            push_back_total <= '0;
        end else if (state_q == IDLE && load_start) begin
            pop_total       <= '0;
            push_back_total <= '0;
        end else begin
            if (pop && pop_total != '1)           pop_total       <= pop_total + 1'b1;
            if (pb_push && push_back_total != '1) push_back_total <= push_back_total + 1'b1;
        end
    end
`endif
endmodule
